bs_fetch_ctrl: RTL
==================

Name: bs_fetch_ctrl

Overview:
Bitstream prefetch controller for the H.264 decoder front end. It fetches 32-bit stream words from external memory into a circular word buffer. Each cycle it presents the 48-bit window starting at the parser's bit pointer `pc`, as BitStream_buffer_output (16 bits) and BitStream_buffer_output_ex32 (32 bits), and raises bs_valid when that window is resident. It sits between the memory arbiter and h264_top, and replaces the flat behavioural bitstream array used in simulation.

Parameters:
DEPTH, 16, buffer depth in 32-bit words; power of 2, minimum 4.
BASE_ADDR, 32'h0, memory word address of stream word 0.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
pc  in  32  absolute stream bit pointer from parser; bit 0 = MSB of word 0
flush  in  1  one-cycle pulse; discard buffer contents and refetch from pc[31:5]
BitStream_buffer_output  out  16  stream bits pc..pc+15
BitStream_buffer_output_ex32  out  32  stream bits pc+16..pc+47
bs_valid  out  1  both windows correct for the pc sampled at the last edge
err_underrun  out  1  sticky; pc moved below the oldest resident word without flush
mem_rd_req  out  1  read request
mem_rd_addr  out  32  word address, BASE_ADDR + word index
mem_rd_ack  in  1  one-cycle acknowledge; data valid in the same cycle
mem_rd_data  in  32  read word; bit 31 is the first stream bit
stall_cnt  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset: all outputs 0. Internal state is also cleared: base = head = 0, drop = 0.
- State:
  - 27-bit word indices `base` (oldest resident word) and `head` (next word to fetch).
  - occupancy = head - base, in the range 0..DEPTH. Buffer slot = index mod DEPTH.
- Fetch handshake:
  - Issue a request when occupancy < DEPTH and no request is outstanding. Set mem_rd_req = 1 and mem_rd_addr = BASE_ADDR + head.
  - req and addr stay stable until ack.
  - On the ack edge, write mem_rd_data to slot head and increment head.
  - req stays 1 with addr + 1 if occupancy after the ack is still < DEPTH, giving back-to-back throughput of 1 word/cycle. Otherwise req drops to 0.
  - At most one request is outstanding.
- Retire: each edge, base <= min(pc[31:5], head) when pc[31:5] > base. Freed slots become fetchable on the same edge.
- Window (registered, latency 1):
  - Let w = pc[31:5] and sh = pc[4:0]. The resident condition is that words w, w+1 and w+2 all satisfy base <= idx < head.
  - Form cat = {word w, word w+1, word w+2}, 96 bits, and shift it left by sh.
  - BitStream_buffer_output <= cat[95:80]; BitStream_buffer_output_ex32 <= cat[79:48].
  - bs_valid <= resident condition.
  - When not resident, the data outputs hold their previous value and bs_valid = 0.
- Underrun: if pc[31:5] < base and flush = 0, set err_underrun to 1 (sticky until reset), and bs_valid = 0.
- Flush:
  - On the edge flush = 1 is sampled: base = head = pc[31:5], bs_valid <= 0.
  - If a request is outstanding, set drop = 1. The next ack is consumed without writing or incrementing head, and drop clears. A new request issues the cycle after that ack.
  - An ack coinciding with flush is dropped.
  - err_underrun is not cleared by flush.
- Wrap-around: index arithmetic is modulo 2^27. Slot indexing is index[log2(DEPTH)-1:0].
- Async reset mid-transfer: req drops immediately. A late ack arriving after reset is ignored, because the post-reset req = 0 state means no outstanding request.

Optional Feature:
- BS_STATS_EN defined: stall_cnt increments on every cycle with bs_valid = 0 after the first cycle bs_valid has been 1 since reset or flush. It saturates at 32'hFFFF_FFFF and clears on reset only.
- BS_STATS_EN undefined: stall_cnt tied to 32'h0 and the counter logic is absent.

Test Plan:
- Memory model word k = 32'hC0DE_0000 | k, ack every cycle. Reset then pc = 0 -> mem_rd_addr 0,1,2,… back-to-back; bs_valid = 1 after word 2 is acked; output = 16'hC0DE, ex32 = 32'h0000_C0DE.
- pc = 8 -> output = 16'hDE00, ex32 = 32'h00C0_DE00. pc = 16 -> output = 16'h0000, ex32 = 32'hC0DE_0001.
- Hold pc = 0, DEPTH = 16 -> exactly 16 requests, then mem_rd_req = 0. Step pc to 32 -> one further request with addr 16.
- Ack delayed 5 cycles, flush with pc = 32'h200 mid-request -> stale ack is dropped; next request addr = 16; bs_valid = 1 with output = 16'hC0DE, ex32 = 32'h0010_C0DE.
- Advance pc to 32'h400, then set pc = 0 without flush -> err_underrun = 1 and stays 1; bs_valid = 0.
- With BS_STATS_EN and ack stalled 10 cycles after the initial fill while pc crosses the resident limit -> stall_cnt = 10. Without BS_STATS_EN -> stall_cnt = 0.

Source files
------------

// File: rtl/bs_fetch_ctrl.sv
// Bitstream prefetch controller: circular word buffer fed from memory, presenting a 48-bit window at the parser bit pointer.
// Optional stall statistics counter enabled by defining BS_STATS_EN; otherwise stall_cnt is tied to zero.
module bs_fetch_ctrl #(
   parameter int unsigned DEPTH     = 16,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] pc,
   input  logic        flush,
   output logic [15:0] BitStream_buffer_output,
   output logic [31:0] BitStream_buffer_output_ex32,
   output logic        bs_valid,
   output logic        err_underrun,
   output logic        mem_rd_req,
   output logic [31:0] mem_rd_addr,
   input  logic        mem_rd_ack,
   input  logic [31:0] mem_rd_data,
   output logic [31:0] stall_cnt
);

   localparam int unsigned   AW        = $clog2(DEPTH);
   localparam logic [26:0]   DEPTH_IDX = 27'(DEPTH);
   localparam logic [26:0]   IDX_ONE   = 27'd1;
   localparam logic [26:0]   IDX_TWO   = 27'd2;
   localparam logic [AW-1:0] SLOT_ONE  = AW'(1);
   localparam logic [AW-1:0] SLOT_TWO  = AW'(2);

   logic [26:0] base_q, base_d;
   logic [26:0] head_q, head_d;
   logic        req_q, req_d;
   logic [31:0] addr_q, addr_d;
   logic        drop_q, drop_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;
   logic [15:0] out16_q, out16_d;
   logic [31:0] out32_q, out32_d;
   logic [31:0] buf_q [DEPTH];

   logic [26:0] w_idx;
   logic [4:0]  sh;
   logic [26:0] occ, occ_n;
   logic [26:0] dist0, dist1, dist2;
   logic [AW-1:0] slot0, slot1, slot2;
   logic [95:0] cat;
   logic [47:0] win;
   logic        resident, ahead, underrun;
   logic        ack_hit, wr_en, held;

   assign w_idx = pc[31:5];
   assign sh    = pc[4:0];
   assign occ   = head_q - base_q;

   // Modular distances keep the resident/behind tests correct across index wrap.
   assign dist0    = w_idx - base_q;
   assign dist1    = (w_idx + IDX_ONE) - base_q;
   assign dist2    = (w_idx + IDX_TWO) - base_q;
   assign resident = (dist0 < occ) && (dist1 < occ) && (dist2 < occ);
   assign ahead    = (dist0 != 27'd0) && !dist0[26];
   assign underrun = dist0[26] && !flush;

   assign slot0 = w_idx[AW-1:0];
   assign slot1 = slot0 + SLOT_ONE;
   assign slot2 = slot0 + SLOT_TWO;
   assign cat   = {buf_q[slot0], buf_q[slot1], buf_q[slot2]};
   assign win   = 48'((cat << sh) >> 48);

   assign ack_hit = req_q && mem_rd_ack;
   assign wr_en   = ack_hit && !drop_q && !flush;
   assign held    = req_q && !mem_rd_ack;

   always_comb begin
      base_d  = base_q;
      head_d  = head_q;
      req_d   = req_q;
      addr_d  = addr_q;
      drop_d  = drop_q;
      valid_d = 1'b0;
      out16_d = out16_q;
      out32_d = out32_q;
      err_d   = err_q | underrun;
      occ_n   = '0;
      if (flush) begin
         // A pending request survives the flush but its data will be discarded.
         base_d = w_idx;
         head_d = w_idx;
         drop_d = held;
         req_d  = 1'b1;
         if (!held) begin
            addr_d = BASE_ADDR + {5'b0, w_idx};
         end
      end else begin
         if (ahead) begin
            base_d = (dist0 < occ) ? w_idx : head_q;
         end
         if (wr_en) begin
            head_d = head_q + IDX_ONE;
         end
         if (ack_hit) begin
            drop_d = 1'b0;
         end
         occ_n = head_d - base_d;
         if (!held) begin
            req_d = (occ_n < DEPTH_IDX);
            if (occ_n < DEPTH_IDX) begin
               addr_d = BASE_ADDR + {5'b0, head_d};
            end
         end
         valid_d = resident && !underrun;
         if (resident) begin
            out16_d = win[47:32];
            out32_d = win[31:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base_q  <= '0;
         head_q  <= '0;
         req_q   <= 1'b0;
         addr_q  <= '0;
         drop_q  <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         out16_q <= '0;
         out32_q <= '0;
      end else begin
         base_q  <= base_d;
         head_q  <= head_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         drop_q  <= drop_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         out16_q <= out16_d;
         out32_q <= out32_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         buf_q[head_q[AW-1:0]] <= mem_rd_data;
      end
   end

   assign BitStream_buffer_output      = out16_q;
   assign BitStream_buffer_output_ex32 = out32_q;
   assign bs_valid                     = valid_q;
   assign err_underrun                 = err_q;
   assign mem_rd_req                   = req_q;
   assign mem_rd_addr                  = addr_q;

`ifdef BS_STATS_EN
   logic        armed_q, armed_d;
   logic [31:0] stall_q, stall_d;

   // Stalls are only counted once the window has been valid since the last reset or flush.
   always_comb begin
      armed_d = flush ? 1'b0 : (armed_q | valid_q);
      stall_d = stall_q;
      if (armed_q && !valid_q && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         armed_q <= 1'b0;
         stall_q <= '0;
      end else begin
         armed_q <= armed_d;
         stall_q <= stall_d;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 32'h0;
`endif

endmodule
